program_loader: RTL and testbench

Writer side of the instruction-memory interface: the processor fetches words at pc, and this block fills that memory. It receives a byte stream (valid/ready) after a start pulse and assembles 32-bit instruction words MSB-first. Each word is written to instruction RAM at consecutive addresses from a base. The stream format is a length header, then the payload, then an XOR checksum. It sits between the host/serial byte source and the instruction RAM write port, and runs before the CPU is released from boot.

---
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction-memory loader: takes a length-prefixed, XOR-checksummed byte stream
// and writes 32-bit words (MSB-first) to consecutive RAM addresses from BASE_ADDR.
module program_loader #(
    parameter int                    ADDR_WIDTH = 26,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_cnt;
    logic [16:0] word_idx;
    logic [16:0] word_idx_inc;
    logic [1:0]  byte_idx;
    logic [7:0]  checksum;
    logic [31:0] word_sr;
    logic        accept;

    assign accept       = byte_valid & byte_ready;
    assign word_idx_inc = word_idx + 17'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LEN_HI;
            LEN_HI:     if (accept) state_nxt = LEN_LO;
            LEN_LO:     if (accept) state_nxt = ({word_cnt[15:8], byte_in} == 16'd0) ? CHECK : DATA;
            DATA:       if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE:      state_nxt = (word_idx_inc == {1'b0, word_cnt}) ? CHECK : DATA;
            CHECK:      if (accept) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            word_sr    <= '0;
        end else begin
            state      <= state_nxt;
            byte_ready <= state_nxt inside {LEN_HI, LEN_LO, DATA, CHECK};
            busy       <= !(state_nxt inside {IDLE, DONE});
            done       <= (state_nxt == DONE);
            mem_we     <= (state == DATA) && (state_nxt == WRITE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        error    <= 1'b0;
                        checksum <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                LEN_HI: if (accept) word_cnt[15:8] <= byte_in;
                LEN_LO: if (accept) word_cnt[7:0] <= byte_in;
                DATA: begin
                    if (accept) begin
                        word_sr  <= {word_sr[23:0], byte_in};
                        checksum <= checksum ^ byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_addr <= BASE_ADDR + ADDR_WIDTH'(word_idx);
                            mem_data <= {word_sr[23:0], byte_in};
                        end
                    end
                end
                WRITE: word_idx <= word_idx_inc;
                CHECK: if (accept) error <= (byte_in != checksum);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a default instance and a 4-bit-address instance at base 14
// share one byte stream; expected writes and flags come from a queue-based model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        d_ready, d_we, d_busy, d_done, d_err;
    logic [25:0] d_addr;
    logic [31:0] d_data;
    logic        w_ready, w_we, w_busy, w_done, w_err;
    logic [3:0]  w_addr;
    logic [31:0] w_data;

    always #5 clk = ~clk;

    program_loader u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(d_ready), .mem_addr(d_addr),
        .mem_data(d_data), .mem_we(d_we), .busy(d_busy), .done(d_done), .error(d_err)
    );

    program_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'd14)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(w_ready), .mem_addr(w_addr),
        .mem_data(w_data), .mem_we(w_we), .busy(w_busy), .done(w_done), .error(w_err)
    );

    typedef struct {
        logic [25:0] a;
        logic [3:0]  aw;
        logic [31:0] d;
    } wr_t;

    wr_t         expq[$];
    wr_t         e;
    logic [31:0] ram_d [16];
    logic [31:0] ram_w [16];
    logic [31:0] wbuf  [8];
    int          wcount = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s", msg);
    endfunction

    function automatic logic [7:0] payload_xor(int n);
        logic [7:0] cs = 8'h00;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++)
                cs ^= wbuf[i][31-8*j -: 8];
        return cs;
    endfunction

    // Every write strobe is checked against the next expected write of the model.
    always @(negedge clk) begin
        if (d_we) begin
            if (expq.size() == 0) begin
                fail($sformatf("unexpected_write addr=%0h data=%0h", d_addr, d_data));
            end else begin
                e = expq.pop_front();
                chk("wr_addr", d_addr, e.a);
                chk("wr_data", d_data, e.d);
                chk("wrap_we", w_we, 1'b1);
                chk("wrap_addr", w_addr, e.aw);
                chk("wrap_data", w_data, e.d);
                chk("ready_in_write", d_ready, 1'b0);
                ram_d[d_addr[3:0]] = d_data;
                ram_w[w_addr] = w_data;
                wcount++;
            end
        end else if (w_we) begin
            fail($sformatf("wrap_we_without_default addr=%0h", w_addr));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall, input bit poke);
        int n;
        if (stall) begin
            n = 0;
            while ($urandom_range(0, 1) == 1 && n < 8) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
                n++;
            end
        end
        byte_in = b;
        byte_valid = 1'b1;
        start = poke;
        n = 0;
        while (!d_ready && n < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (n >= 50) fail($sformatf("byte_timeout byte=%0h", b));
        @(posedge clk); #1;
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_load(input int n, input bit stall, input logic [7:0] flip, input int poke_at);
        logic [7:0] cs;
        int k;
        int m;
        cs = payload_xor(n);
        for (int i = 0; i < n; i++)
            expq.push_back('{a: 26'(i), aw: 4'(14 + i), d: wbuf[i]});
        wcount = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_clears_done", d_done, 1'b0);
        chk("start_clears_error", d_err, 1'b0);
        chk("busy_after_start", d_busy, 1'b1);
        chk("wrap_busy_after_start", w_busy, 1'b1);
        send_byte(n[15:8], stall, 1'b0);
        send_byte(n[7:0], stall, 1'b0);
        k = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++) begin
                send_byte(wbuf[i][31-8*j -: 8], stall, k == poke_at);
                k++;
            end
        send_byte(cs ^ flip, stall, 1'b0);
        m = 0;
        while (!d_done && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        chk("done", d_done, 1'b1);
        chk("error", d_err, flip != 8'h00);
        chk("busy_after_done", d_busy, 1'b0);
        chk("wrap_done", w_done, 1'b1);
        chk("wrap_error", w_err, flip != 8'h00);
        chk("write_count", wcount, n);
        chk("pending_writes", expq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_d[i] = '0;
            ram_w[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", d_ready, 1'b0);
        chk("rst_busy", d_busy, 1'b0);
        chk("rst_done", d_done, 1'b0);
        chk("rst_error", d_err, 1'b0);
        chk("rst_we", d_we, 1'b0);
        chk("rst_addr", d_addr, 26'd0);
        chk("rst_data", d_data, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_not_busy", d_busy, 1'b0);

        // Nominal two-word load
        wbuf[0] = 32'hF000002F;
        wbuf[1] = 32'h047BC002;
        chk("model_checksum", payload_xor(2), 8'h62);
        do_load(2, 1'b0, 8'h00, -1);
        chk("ram0", ram_d[0], 32'hF000002F);
        chk("ram1", ram_d[1], 32'h047BC002);
        chk("wram14", ram_w[14], 32'hF000002F);
        chk("wram15", ram_w[15], 32'h047BC002);

        // Bad checksum; the following load's start must clear the flags
        do_load(2, 1'b0, 8'h01, -1);

        // Zero length: good then bad checksum byte
        do_load(0, 1'b0, 8'h00, -1);
        do_load(0, 1'b0, 8'h05, -1);

        // Three words, straight then stalled with a stray start mid-load
        wbuf[0] = 32'h11223344;
        wbuf[1] = 32'h55667788;
        wbuf[2] = 32'h99AABBCC;
        do_load(3, 1'b0, 8'h00, -1);
        chk("wram0_wrap", ram_w[0], 32'h99AABBCC);
        chk("wram14_wrap", ram_w[14], 32'h11223344);
        chk("ram2", ram_d[2], 32'h99AABBCC);
        for (int i = 0; i < 16; i++) begin
            ram_d[i] = '0;
            ram_w[i] = '0;
        end
        do_load(3, 1'b1, 8'h00, 5);
        chk("stall_ram0", ram_d[0], 32'h11223344);
        chk("stall_ram1", ram_d[1], 32'h55667788);
        chk("stall_wram0", ram_w[0], 32'h99AABBCC);

        // Asynchronous reset in the middle of the payload
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b0, 1'b0);
        chk("mid_load_busy", d_busy, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", d_ready, 1'b0);
        chk("arst_busy", d_busy, 1'b0);
        chk("arst_done", d_done, 1'b0);
        chk("arst_we", d_we, 1'b0);
        chk("arst_addr", d_addr, 26'd0);
        chk("arst_data", d_data, 32'd0);
        chk("arst_wrap_addr", w_addr, 4'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("after_arst_idle", d_busy, 1'b0);
        do_load(2, 1'b0, 8'h00, -1);
        chk("post_reset_ram1", ram_d[1], 32'h55667788);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
